note_sampler: RTL

NOTE_SAMPLER -- requirements
Module: note_sampler

---
 rtl/note_sampler.sv | 95 +++++++++
 1 files changed

// File: rtl/note_sampler.sv
// note_sampler: draws a class index from an unnormalized score vector by
// scaling a uniform random fraction of the total and scanning the cumulative sum.
module note_sampler #(
  parameter  int NUM_CLASSES = 128,
  parameter  int PW          = 16,
  parameter  int DW          = 40,
  parameter  int RW          = 16,
  localparam int IW          = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int SW          = PW + IW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] rnd_in,
  input  logic          prob_valid,
  input  logic [PW-1:0] prob_data,
  input  logic          prob_last,
  output logic          prob_ready,
  output logic          sample_valid,
  output logic [IW-1:0] sample_idx,
  output logic          sample_zero,
  output logic          busy
);
  typedef enum logic [2:0] {IDLE, LOAD, SCALE, SCAN, DONE} state_t;
  state_t state;
  logic [PW-1:0] mem [NUM_CLASSES];
  logic [RW-1:0] r;
  logic [SW-1:0] total, thr, cum, cum_next;
  logic [IW:0] count;
  logic [IW-1:0] i;
  logic [SW+RW-1:0] prod;
  logic accept, last_beat, hit;
  logic rnd_unused;
  assign rnd_unused = ^rnd_in;
  assign prob_ready = state == LOAD;
  assign busy = state != IDLE;
  assign accept = prob_valid && prob_ready;
  assign last_beat = prob_last || count == (IW+1)'(NUM_CLASSES - 1);
  assign prod = (SW+RW)'(total) * (SW+RW)'(r);
  assign cum_next = cum + SW'(mem[i]);
  // the last loaded entry is taken unconditionally so rounding in the threshold can never fall through
  assign hit = cum_next > thr || {1'b0, i} == count - 1'b1;
  always_ff @(posedge clk)
    if (accept) mem[count[IW-1:0]] <= prob_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      r <= '0;
      total <= '0;
      thr <= '0;
      cum <= '0;
      count <= '0;
      i <= '0;
      sample_valid <= 1'b0;
      sample_idx <= '0;
      sample_zero <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          r <= rnd_in[RW-1:0];
          total <= '0;
          count <= '0;
        end
        LOAD: if (accept) begin
          total <= total + SW'(prob_data);
          count <= count + 1'b1;
          if (last_beat) state <= SCALE;
        end
        SCALE: begin
          thr <= SW'(prod >> RW);
          cum <= '0;
          i <= '0;
          if (total == '0) begin
            state <= DONE;
            sample_valid <= 1'b1;
            sample_idx <= '0;
            sample_zero <= 1'b1;
          end else state <= SCAN;
        end
        SCAN: if (hit) begin
          state <= DONE;
          sample_valid <= 1'b1;
          sample_idx <= i;
          sample_zero <= 1'b0;
        end else begin
          cum <= cum_next;
          i <= i + 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
